seg7_rotation_decoder: RTL

Receive-side counterpart to the character-rotation display driver. Samples the four active-low 7-segment code buses and decodes each back to its 2-bit character code (d, E, 1, blank). Qualifies the pattern with a stability filter, identifies the rotation position, and flags illegal glyphs, illegal patterns and out-of-sequence rotation steps. Sits beside the display driver in self-checking builds and on the board as a loopback monitor.

---
 rtl/seg7_rotation_decoder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_rotation_decoder.sv
// Loopback monitor for the character-rotation display: decodes four 7-segment buses and locks onto the rotation.
// Optional saturating seq_err counter is built only when SEG7_ROT_ERRCNT_EN is defined.
module seg7_rotation_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] code1,
    input  logic [6:0] code2,
    input  logic [6:0] code3,
    input  logic [6:0] code4,
    output logic [1:0] char1,
    output logic [1:0] char2,
    output logic [1:0] char3,
    output logic [1:0] char4,
    output logic       char_ok,
    output logic [1:0] rot,
    output logic       locked,
    output logic       step,
    output logic       seq_err,
    output logic [7:0] err_count
);

    localparam logic [8:0] STABLE_W = 9'(STABLE_CYCLES);
    localparam logic [7:0] BASE_WORD = 8'h1B;  // {d, E, 1, blank}, leftmost display in the top bits

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_LOCKED
    } state_t;

    // Raw segment image; primed_reg masks char_ok until a real sample has been taken.
    logic [27:0] code_reg;
    logic        primed_reg;
    logic [27:0] code_in;
    logic [7:0]  char_word;
    logic [3:0]  glyph_ok;
    logic [3:0]  rot_match;
    logic [1:0]  pat_r;
    logic        legal;
    logic        single_cycle_lock;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [1:0]  cand_reg, cand_next;
    logic [1:0]  rot_reg, rot_next;
    logic        locked_reg, locked_next;
    logic        step_reg, step_next;
    logic        seq_err_reg, seq_err_next;

    assign code_in = {code4, code3, code2, code1};

    always_ff @(posedge clk) begin
        if (reset) begin
            code_reg   <= '1;
            primed_reg <= 1'b0;
        end else begin
            code_reg   <= code_in;
            primed_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_glyph
            logic [6:0] seg;
            assign seg = code_reg[gi*7 +: 7];
            always_comb begin
                char_word[gi*2 +: 2] = 2'b11;
                glyph_ok[gi]         = 1'b1;
                case (seg)
                    7'b0100001: char_word[gi*2 +: 2] = 2'b00;
                    7'b0000110: char_word[gi*2 +: 2] = 2'b01;
                    7'b1111001: char_word[gi*2 +: 2] = 2'b10;
                    7'b1111111: char_word[gi*2 +: 2] = 2'b11;
                    default:    glyph_ok[gi]         = 1'b0;
                endcase
            end
        end

        // Rotation gi is the base word rotated left by gi character positions.
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [7:0] ROT_WORD =
                8'((BASE_WORD << (2 * gi)) | (BASE_WORD >> ((8 - 2 * gi) % 8)));
            assign rot_match[gi] = (char_word == ROT_WORD);
        end
    endgenerate

    always_comb begin
        pat_r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rot_match[i]) begin
                pat_r = 2'(i);
            end
        end
    end

    assign char_ok           = primed_reg & (&glyph_ok);
    assign legal             = char_ok & (|rot_match);
    assign single_cycle_lock = (STABLE_W <= 9'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 8'd0;
            cand_reg    <= 2'd0;
            rot_reg     <= 2'd0;
            locked_reg  <= 1'b0;
            step_reg    <= 1'b0;
            seq_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cand_reg    <= cand_next;
            rot_reg     <= rot_next;
            locked_reg  <= locked_next;
            step_reg    <= step_next;
            seq_err_reg <= seq_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cand_next    = cand_reg;
        rot_next     = rot_reg;
        locked_next  = locked_reg;
        step_next    = 1'b0;
        seq_err_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (legal) begin
                    cand_next = pat_r;
                    cnt_next  = 8'd1;
                    if (single_cycle_lock) begin
                        state_next  = S_LOCKED;
                        rot_next    = pat_r;
                        locked_next = 1'b1;
                    end else begin
                        state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!legal) begin
                    state_next  = S_IDLE;
                    locked_next = 1'b0;
                end else if (pat_r == cand_reg) begin
                    if (({1'b0, cnt_reg} + 9'd1) >= STABLE_W) begin
                        state_next  = S_LOCKED;
                        rot_next    = cand_reg;
                        locked_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end else begin
                    cand_next = pat_r;
                    cnt_next  = 8'd1;
                    if (single_cycle_lock) begin
                        state_next  = S_LOCKED;
                        rot_next    = pat_r;
                        locked_next = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (!legal) begin
                    seq_err_next = 1'b1;
                    locked_next  = 1'b0;
                    state_next   = S_IDLE;
                end else if (pat_r != rot_reg) begin
                    // A +1 step keeps the old lock visible while the new rotation settles.
                    if (pat_r == 2'(rot_reg + 2'd1)) begin
                        step_next = 1'b1;
                    end else begin
                        seq_err_next = 1'b1;
                        locked_next  = 1'b0;
                    end
                    cand_next = pat_r;
                    cnt_next  = 8'd1;
                    if (single_cycle_lock) begin
                        state_next  = S_LOCKED;
                        rot_next    = pat_r;
                        locked_next = 1'b1;
                    end else begin
                        state_next = S_SETTLE;
                    end
                end
            end
            default: begin
                state_next  = S_IDLE;
                locked_next = 1'b0;
            end
        endcase
    end

`ifdef SEG7_ROT_ERRCNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= 8'd0;
        end else if (seq_err_next && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'd0;
`endif

    assign char1   = char_word[1:0];
    assign char2   = char_word[3:2];
    assign char3   = char_word[5:4];
    assign char4   = char_word[7:6];
    assign rot     = rot_reg;
    assign locked  = locked_reg;
    assign step    = step_reg;
    assign seq_err = seq_err_reg;

endmodule
